// File: rtl/iquant_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iquant_pkg - constants, FSM states and clip helper for inverse_quant_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
package iquant_pkg;

  localparam int IQUANT_SHIFT = 6;
  localparam int MAX_QP       = 51;
  localparam int SCALE_W      = 7;
  localparam int CLIP_W       = 48;

  localparam logic [SCALE_W-1:0] INV_SCALE [6] = '{7'd40, 7'd45, 7'd51, 7'd57, 7'd64, 7'd72};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV   = 3'd1,
    SETUP = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  function automatic logic signed [CLIP_W-1:0] clip(
    input logic signed [CLIP_W-1:0] v,
    input logic signed [CLIP_W-1:0] lo,
    input logic signed [CLIP_W-1:0] hi
  );
    logic signed [CLIP_W-1:0] r;
    r = v;
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iquant_datapath.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iquant_datapath - 3-stage multiply / round-shift / saturate with global stall
// Rev 1.0   (IQUANT_SAT_STATS_EN adds the out_sat_o flag)
// ----------------------------------------------------------------------------
module iquant_datapath
  import iquant_pkg::*;
#(
  parameter int LEVEL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic signed [LEVEL_W-1:0] level_i,
  input  logic                      last_i,
  input  logic [SCALE_W-1:0]        scale_i,
  input  logic signed [5:0]         rshift_i,
  input  logic                      out_ready_i,
  output logic                      advance_o,
  output logic                      busy_o,
  output logic                      out_valid_o,
  output logic signed [LEVEL_W-1:0] out_coeff_o,
  output logic                      out_last_o
`ifdef IQUANT_SAT_STATS_EN
  ,
  output logic                      out_sat_o
`endif
);

  localparam int PROD_W = LEVEL_W + SCALE_W;
  // Left shifts reach 17 (qp_per 8 + tshift 15 - 6), so keep 18 guard bits.
  localparam int WIDE_W = PROD_W + 18;
  localparam logic signed [CLIP_W-1:0] C_MAX = {{(CLIP_W-LEVEL_W+1){1'b0}}, {(LEVEL_W-1){1'b1}}};
  localparam logic signed [CLIP_W-1:0] C_MIN = {{(CLIP_W-LEVEL_W+1){1'b1}}, {(LEVEL_W-1){1'b0}}};

  logic                      s1_valid_q, s2_valid_q, out_valid_q;
  logic                      s1_last_q, s2_last_q, out_last_q;
  logic signed [PROD_W-1:0]  s1_prod_q;
  logic signed [WIDE_W-1:0]  s2_val_q;
  logic signed [LEVEL_W-1:0] out_coeff_q;

  logic                      w_stall;
  logic signed [PROD_W-1:0]  w_lvl_ext, w_scl_ext, w_prod;
  logic signed [WIDE_W-1:0]  w_prod_wide, w_rnd, w_sum, w_shift_d;
  logic [5:0]                w_rsh, w_lsh;
  logic signed [CLIP_W-1:0]  w_s2_ext;

  assign w_stall     = out_valid_q && !out_ready_i;
  assign advance_o   = !w_stall;
  assign busy_o      = s1_valid_q || s2_valid_q || out_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_coeff_o = out_coeff_q;
  assign out_last_o  = out_last_q;

  assign w_lvl_ext = PROD_W'(level_i);
  assign w_scl_ext = $signed({{(PROD_W-SCALE_W){1'b0}}, scale_i});
  assign w_prod    = w_lvl_ext * w_scl_ext;

  assign w_prod_wide = WIDE_W'(s1_prod_q);
  assign w_rsh       = $unsigned(rshift_i);
  assign w_lsh       = 6'(-rshift_i);
  assign w_rnd       = $signed({{(WIDE_W-1){1'b0}}, 1'b1} << (w_rsh - 6'd1));
  assign w_sum       = w_prod_wide + w_rnd;

  always_comb begin
    w_shift_d = w_prod_wide <<< w_lsh;
    if (rshift_i > 6'sd0) begin
      w_shift_d = w_sum >>> w_rsh;
    end
  end

  assign w_s2_ext = CLIP_W'(s2_val_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      out_last_q  <= 1'b0;
      s1_prod_q   <= '0;
      s2_val_q    <= '0;
      out_coeff_q <= '0;
    end else if (advance_o) begin
      s1_valid_q  <= push_i;
      s1_last_q   <= push_i && last_i;
      s1_prod_q   <= w_prod;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_val_q    <= w_shift_d;
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_last_q;
      out_coeff_q <= LEVEL_W'(clip(w_s2_ext, C_MIN, C_MAX));
    end
  end

`ifdef IQUANT_SAT_STATS_EN
  logic out_sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sat_q <= 1'b0;
    end else if (advance_o) begin
      out_sat_q <= s2_valid_q && ((w_s2_ext > C_MAX) || (w_s2_ext < C_MIN));
    end
  end

  assign out_sat_o = out_sat_q;
`endif

endmodule
`default_nettype wire

// File: rtl/inverse_quant_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inverse_quant_pipe - streaming HEVC dequantizer with per-block config FSM
// Rev 1.0   (IQUANT_SAT_STATS_EN adds the sat_count output)
// ----------------------------------------------------------------------------
module inverse_quant_pipe
  import iquant_pkg::*;
#(
  parameter int LEVEL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [5:0]                cfg_qp,
  input  logic [5:0]                cfg_tshift,
  input  logic [2:0]                cfg_log2_size,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [LEVEL_W-1:0] in_level,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [LEVEL_W-1:0] out_coeff,
  output logic                      out_last,
  output logic                      busy
`ifdef IQUANT_SAT_STATS_EN
  ,
  output logic [15:0]               sat_count
`endif
);

  state_e             state_q;
  logic [5:0]         qp_rem_q;
  logic [3:0]         qp_per_q;
  logic [5:0]         tshift_q;
  logic [2:0]         log2_q;
  logic [SCALE_W-1:0] scale_q;
  logic signed [5:0]  rshift_q;
  logic [9:0]         cnt_q;
  logic               cfg_err_q;

  logic w_cfg_fire, w_cfg_bad, w_in_fire, w_out_fire, w_advance, w_dp_busy, w_out_sat;

  assign cfg_ready  = (state_q == IDLE);
  assign in_ready   = (state_q == RUN) && w_advance;
  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_cfg_bad  = (cfg_qp > 6'(MAX_QP)) || (cfg_log2_size < 3'd2) || (cfg_log2_size > 3'd5);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q != IDLE) || w_dp_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      qp_rem_q  <= '0;
      qp_per_q  <= '0;
      tshift_q  <= '0;
      log2_q    <= '0;
      scale_q   <= '0;
      rshift_q  <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_cfg_fire) begin
            if (w_cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              qp_rem_q <= cfg_qp;
              qp_per_q <= 4'd0;
              tshift_q <= cfg_tshift;
              log2_q   <= cfg_log2_size;
              state_q  <= DIV;
            end
          end
        end
        DIV: begin
          if (qp_rem_q >= 6'd6) begin
            qp_rem_q <= qp_rem_q - 6'd6;
            qp_per_q <= qp_per_q + 4'd1;
          end else begin
            state_q <= SETUP;
          end
        end
        SETUP: begin
          scale_q  <= INV_SCALE[qp_rem_q[2:0]];
          rshift_q <= $signed(6'(IQUANT_SHIFT) - {2'b00, qp_per_q} - tshift_q);
          // Low 2*log2 bits set: coefficient count minus one.
          cnt_q    <= ~(10'h3FF << {log2_q, 1'b0});
          state_q  <= RUN;
        end
        RUN: begin
          if (w_in_fire) begin
            if (cnt_q == 10'd0) begin
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q - 10'd1;
            end
          end
        end
        DRAIN: begin
          if (w_out_fire && out_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  iquant_datapath #(
    .LEVEL_W (LEVEL_W)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_in_fire),
    .level_i     (in_level),
    .last_i      (cnt_q == 10'd0),
    .scale_i     (scale_q),
    .rshift_i    (rshift_q),
    .out_ready_i (out_ready),
    .advance_o   (w_advance),
    .busy_o      (w_dp_busy),
    .out_valid_o (out_valid),
    .out_coeff_o (out_coeff),
    .out_last_o  (out_last)
`ifdef IQUANT_SAT_STATS_EN
    ,
    .out_sat_o   (w_out_sat)
`endif
  );

`ifdef IQUANT_SAT_STATS_EN
  logic [15:0] sat_count_q;

  always_ff @(posedge clk) begin
    if (rst || w_cfg_fire) begin
      sat_count_q <= '0;
    end else if (w_out_fire && w_out_sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_q <= sat_count_q + 16'd1;
    end
  end

  assign sat_count = sat_count_q;
`else
  assign w_out_sat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inverse_quant_pipe.sv
`default_nettype none
// Self-checking bench for inverse_quant_pipe: directed configs, random backpressure, reset.
module tb_inverse_quant_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid, cfg_ready, cfg_err;
  logic [5:0]         cfg_qp, cfg_tshift;
  logic [2:0]         cfg_log2_size;
  logic               in_valid, in_ready;
  logic signed [15:0] in_level;
  logic               out_valid, out_ready, out_last, busy;
  logic signed [15:0] out_coeff;
`ifdef IQUANT_SAT_STATS_EN
  logic [15:0]        sat_count;
`endif

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;

  logic signed [15:0] got_q[$];
  logic               got_last_q[$];
  logic signed [15:0] exp_q[$];

  inverse_quant_pipe #(.LEVEL_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_qp        (cfg_qp),
    .cfg_tshift    (cfg_tshift),
    .cfg_log2_size (cfg_log2_size),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_level      (in_level),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_coeff     (out_coeff),
    .out_last      (out_last),
    .busy          (busy)
`ifdef IQUANT_SAT_STATS_EN
    ,
    .sat_count     (sat_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Outputs are recorded at the negedge preceding the accepting posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !rst) begin
        got_q.push_back(out_coeff);
        got_last_q.push_back(out_last);
      end
    end
  end

  function automatic logic signed [15:0] model(input int qp, input int ts, input int lv);
    int     sc [6];
    int     rs;
    longint p, r;
    sc = '{40, 45, 51, 57, 64, 72};
    rs = 6 - (qp / 6) - ts;
    p  = longint'(lv) * longint'(sc[qp % 6]);
    if (rs > 0) r = (p + (longint'(1) << (rs - 1))) >>> rs;
    else        r = p * (longint'(1) << (-rs));
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic do_cfg(input logic [5:0] qp, input logic [5:0] ts, input logic [2:0] l2);
    int t = 0;
    cfg_valid = 1'b1; cfg_qp = qp; cfg_tshift = ts; cfg_log2_size = l2;
    while (!cfg_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) begin
      checks++; failures++;
      $display("FAIL cfg_timeout got=cfg_ready0 exp=cfg_ready1");
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] lv);
    int t = 0;
    in_valid = 1'b1; in_level = lv;
    while (!in_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) begin
      checks++; failures++;
      $display("FAIL send_timeout got=in_ready0 exp=in_ready1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 20000) begin @(negedge clk); t++; end
    if (t >= 20000) begin
      checks++; failures++;
      $display("FAIL idle_timeout got=busy1 exp=busy0");
    end
    @(negedge clk);
  endtask

  task automatic clear_q();
    got_q.delete(); got_last_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; in_level = '0;
    cfg_qp = '0; cfg_tshift = '0; cfg_log2_size = 3'd2;
    repeat (3) @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (in_ready  !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_coeff !== 16'sd0) begin failures++; $display("FAIL rst_out_coeff got=%0d exp=0", out_coeff); end
    checks++; if (out_last  !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (cfg_err   !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (busy      !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // qp30 ts4: per 5, rem 0, scale 40, rshift -3
  task automatic test_qp30_block();
    logic signed [15:0] e;
    clear_q(); ready_mode = 0;
    do_cfg(6'd30, 6'd4, 3'd2);
    for (int i = 0; i < 16; i++) send((i % 2 == 1) ? -16'sd2 : 16'sd3);
    wait_idle();
    checks++;
    if (got_q.size() != 16) begin failures++; $display("FAIL qp30_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      e = (i % 2 == 1) ? -16'sd640 : 16'sd960;
      checks++;
      if (got_q[i] !== e) begin failures++; $display("FAIL qp30_val[%0d] got=%0d exp=%0d", i, got_q[i], e); end
      checks++;
      if (got_last_q[i] !== (i == 15)) begin failures++; $display("FAIL qp30_last[%0d] got=%b exp=%b", i, got_last_q[i], (i == 15)); end
    end
  endtask

  task automatic run_simple(input string name, input logic [5:0] qp, input logic [5:0] ts,
                            input logic signed [15:0] l0, input logic signed [15:0] l1,
                            input logic signed [15:0] l2v, input logic signed [15:0] e0,
                            input logic signed [15:0] e1, input logic signed [15:0] e2);
    clear_q(); ready_mode = 0;
    do_cfg(qp, ts, 3'd2);
    send(l0); send(l1); send(l2v);
    for (int i = 3; i < 16; i++) send(16'sd0);
    wait_idle();
    checks++;
    if (got_q.size() != 16) begin
      failures++; $display("FAIL %s_count got=%0d exp=16", name, got_q.size());
    end else begin
      checks++; if (got_q[0] !== e0) begin failures++; $display("FAIL %s_v0 got=%0d exp=%0d", name, got_q[0], e0); end
      checks++; if (got_q[1] !== e1) begin failures++; $display("FAIL %s_v1 got=%0d exp=%0d", name, got_q[1], e1); end
      checks++; if (got_q[2] !== e2) begin failures++; $display("FAIL %s_v2 got=%0d exp=%0d", name, got_q[2], e2); end
      checks++; if (got_q[15] !== 16'sd0) begin failures++; $display("FAIL %s_v15 got=%0d exp=0", name, got_q[15]); end
    end
  endtask

  task automatic test_qp12();
    run_simple("qp12", 6'd12, 6'd2, 16'sd5, -16'sd5, 16'sd0, 16'sd50, -16'sd50, 16'sd0);
  endtask

  task automatic test_saturate();
    run_simple("sat", 6'd51, 6'd6, 16'sd1000, -16'sd1000, 16'sd1, 16'sd32767, -16'sh8000, 16'sd14592);
`ifdef IQUANT_SAT_STATS_EN
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count got=%0d exp=2", sat_count); end
`endif
  endtask

  task automatic test_qp0();
    run_simple("qp0", 6'd0, 6'd0, 16'sd64, -16'sd64, 16'sd1, 16'sd40, -16'sd40, 16'sd1);
  endtask

  task automatic test_random_backpressure();
    int lv;
    clear_q(); ready_mode = 1;
    do_cfg(6'd27, 6'd1, 3'd5);
    for (int i = 0; i < 1024; i++) begin
      lv = int'($urandom_range(0, 4000)) - 2000;
      exp_q.push_back(model(27, 1, lv));
      send(16'(lv));
    end
    wait_idle();
    ready_mode = 0;
    checks++;
    if (got_q.size() != 1024) begin failures++; $display("FAIL rnd_count got=%0d exp=1024", got_q.size()); end
    for (int i = 0; i < 1024 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 1023)) begin
        failures++;
        $display("FAIL rnd[%0d] got=%0d/last%b exp=%0d/last%b", i, got_q[i], got_last_q[i], exp_q[i], (i == 1023));
      end
    end
  endtask

  task automatic test_illegal_cfg();
    do_cfg(6'd52, 6'd0, 3'd2);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL bad_qp_err got=%b exp=1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_qp_idle got=ready%b/busy%b exp=ready1/busy0", cfg_ready, busy); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL bad_qp_pulse got=%b exp=0", cfg_err); end
    do_cfg(6'd10, 6'd0, 3'd6);
    checks++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL bad_size got=err%b/ready%b exp=err1/ready1", cfg_err, cfg_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    clear_q(); ready_mode = 2;
    repeat (2) @(negedge clk);
    do_cfg(6'd20, 6'd0, 3'd3);
    send(16'sd7); send(16'sd8); send(16'sd9);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    rst = 1'b0; ready_mode = 0;
    repeat (2) @(negedge clk);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL mid_rst_leak got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; in_level = '0;
    cfg_qp = '0; cfg_tshift = '0; cfg_log2_size = 3'd2;
    @(negedge clk);
    test_reset();
    test_qp30_block();
    test_qp12();
    test_saturate();
    test_illegal_cfg();
    test_random_backpressure();
    test_reset_mid_run();
    test_qp0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
